// File: rtl/hermes_input_buffer.sv
// Hermes router per-port input stage: circular FWFT flit FIFO with link credits, plus packet FSM.
// Optional HERMES_BUFFER_OCC_EN adds occupancy_o and a sticky overflow_o.
module hermes_input_buffer #(
   parameter int FLIT_SIZE   = 32,
   parameter int BUFFER_SIZE = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 rx_i,
   input  logic [FLIT_SIZE-1:0] data_i,
   output logic                 credit_o,
   output logic                 req_o,
   input  logic                 ack_i,
   output logic                 sending_o,
   output logic                 tx_o,
   output logic [FLIT_SIZE-1:0] data_o,
   input  logic                 credit_i
`ifdef HERMES_BUFFER_OCC_EN
   ,
   output logic [$clog2(BUFFER_SIZE):0] occupancy_o,
   output logic                         overflow_o
`endif
);

   localparam int AW = $clog2(BUFFER_SIZE);
   localparam int PW = AW + 1;

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_HEADER, S_SIZE, S_PAYLOAD} state_t;

   state_t               state_q;
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [FLIT_SIZE-1:0] mem_q [BUFFER_SIZE];
   logic [FLIT_SIZE-1:0] cnt_q;
   logic                 req_q, sending_q;
   logic                 full, empty, wr_en, rd_en;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign credit_o = !full;
   assign wr_en    = rx_i && !full;
   assign tx_o     = sending_q && !empty;
   assign rd_en    = tx_o && credit_i;
   assign data_o   = mem_q[rd_ptr_q[AW-1:0]];
   assign req_o    = req_q;
   assign sending_o = sending_q;

   assign wr_ptr_d = wr_ptr_q + PW'(wr_en);
   assign rd_ptr_d = rd_ptr_q + PW'(rd_en);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

   // Leaving S_IDLE always costs one cycle, so sending_o is seen low between packets.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= S_IDLE;
         req_q     <= 1'b0;
         sending_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!empty) begin
                  state_q <= S_REQ;
                  req_q   <= 1'b1;
               end
            end
            S_REQ: begin
               if (ack_i) begin
                  state_q   <= S_HEADER;
                  req_q     <= 1'b0;
                  sending_q <= 1'b1;
               end
            end
            S_HEADER: begin
               if (rd_en) state_q <= S_SIZE;
            end
            S_SIZE: begin
               if (rd_en) begin
                  cnt_q <= data_o;
                  if (data_o == '0) begin
                     state_q   <= S_IDLE;
                     sending_q <= 1'b0;
                  end else begin
                     state_q <= S_PAYLOAD;
                  end
               end
            end
            S_PAYLOAD: begin
               if (rd_en) begin
                  cnt_q <= cnt_q - FLIT_SIZE'(1);
                  if (cnt_q == FLIT_SIZE'(1)) begin
                     state_q   <= S_IDLE;
                     sending_q <= 1'b0;
                  end
               end
            end
            default: begin
               state_q   <= S_IDLE;
               req_q     <= 1'b0;
               sending_q <= 1'b0;
            end
         endcase
      end
   end

`ifdef HERMES_BUFFER_OCC_EN
   logic overflow_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)            overflow_q <= 1'b0;
      else if (rx_i && full)  overflow_q <= 1'b1;
   end

   assign occupancy_o = wr_ptr_q - rd_ptr_q;
   assign overflow_o  = overflow_q;
`endif

endmodule

// File: tb/tb_hermes_input_buffer.sv
// Directed bench for hermes_input_buffer: inputs change and outputs are sampled on the falling edge.
module tb_hermes_input_buffer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rx = 1'b0;
   logic        ack = 1'b0;
   logic        credit_in = 1'b0;
   logic [31:0] din = '0;
   logic        credit_o, req_o, sending_o, tx_o;
   logic [31:0] data_o;
`ifdef HERMES_BUFFER_OCC_EN
   logic [3:0]  occ;
   logic        ovf;
`endif

   int checks = 0;
   int errors = 0;
   logic [31:0] stim [20];
   int wi, ri;

   always #5 clk = ~clk;

   hermes_input_buffer #(.FLIT_SIZE(32), .BUFFER_SIZE(8)) dut (
      .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .data_i(din), .credit_o(credit_o),
      .req_o(req_o), .ack_i(ack), .sending_o(sending_o), .tx_o(tx_o),
      .data_o(data_o), .credit_i(credit_in)
`ifdef HERMES_BUFFER_OCC_EN
      , .occupancy_o(occ), .overflow_o(ovf)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [31:0] d);
      rx = 1'b1;
      din = d;
      step();
      rx = 1'b0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 30 && !req_o; i++) step();
      chk("req_wait", req_o, 1);
   endtask

   task automatic grant();
      ack = 1'b1;
      step();
      ack = 1'b0;
   endtask

   task automatic take(input string tag, input logic [31:0] exp);
      credit_in = 1'b1;
      for (int i = 0; i < 30 && !tx_o; i++) step();
      chk({tag, "_tx"}, tx_o, 1);
      chk(tag, data_o, exp);
      step();
   endtask

   initial begin
      credit_in = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_credit", credit_o, 1);
      chk("rst_req", req_o, 0);
      chk("rst_sending", sending_o, 0);
      chk("rst_tx", tx_o, 0);
`ifdef HERMES_BUFFER_OCC_EN
      chk("rst_occ", occ, 0);
      chk("rst_ovf", ovf, 0);
`endif
      rst_n = 1'b1;

      // Basic packet, ack three cycles after req_o rises
      send(32'h0000_0101);
      chk("t1_req_early", req_o, 0);
      send(32'd2);
      chk("t1_req_rise", req_o, 1);
      send(32'h0000_000A);
      chk("t1_req_hold1", req_o, 1);
      send(32'h0000_000B);
      chk("t1_req_hold2", req_o, 1);
      grant();
      chk("t1_req_fall", req_o, 0);
      chk("t1_sending", sending_o, 1);
      take("t1_hdr", 32'h0000_0101);
      take("t1_size", 32'd2);
      take("t1_pA", 32'h0000_000A);
      chk("t1_sending_mid", sending_o, 1);
      take("t1_pB", 32'h0000_000B);
      chk("t1_sending_end", sending_o, 0);
      chk("t1_tx_end", tx_o, 0);
      step();
      chk("t1_idle_req", req_o, 0);

      // Fill to full without acking; the ninth flit must be dropped
      for (int k = 0; k < 8; k++) begin
         chk("t2_credit_open", credit_o, 1);
         send(k == 0 ? 32'h0000_0111 : (k == 1 ? 32'd6 : 32'h20 + k - 2));
      end
      chk("t2_credit_full", credit_o, 0);
      send(32'h0000_DEAD);
      chk("t2_credit_still", credit_o, 0);
`ifdef HERMES_BUFFER_OCC_EN
      chk("t2_occ", occ, 8);
      chk("t2_ovf", ovf, 1);
`endif
      wait_req();
      grant();
      take("t2_hdr", 32'h0000_0111);
      take("t2_size", 32'd6);
      for (int k = 0; k < 6; k++) take("t2_pay", 32'h20 + k);
      chk("t2_sending_end", sending_o, 0);
      step();
      step();
      chk("t2_no_extra_req", req_o, 0);
      chk("t2_empty_credit", credit_o, 1);

      // Zero-size packet followed by a one-flit packet already queued
      send(32'h0000_0202);
      send(32'd0);
      send(32'h0000_0303);
      send(32'd1);
      send(32'h0000_000C);
      wait_req();
      grant();
      take("t3_hdr0", 32'h0000_0202);
      take("t3_size0", 32'd0);
      chk("t3_sending_fall", sending_o, 0);
      chk("t3_idle_gap", req_o, 0);
      step();
      chk("t3_next_req", req_o, 1);
      grant();
      take("t3_hdr1", 32'h0000_0303);
      take("t3_size1", 32'd1);
      take("t3_pC", 32'h0000_000C);
      chk("t3_sending_end", sending_o, 0);

      // Downstream stalls: credit_i 1,0,0,1 across the payload
      send(32'h0000_0404);
      send(32'd3);
      send(32'h11);
      send(32'h22);
      send(32'h33);
      wait_req();
      grant();
      take("t4_hdr", 32'h0000_0404);
      take("t4_size", 32'd3);
      take("t4_p1", 32'h11);
      credit_in = 1'b0;
      chk("t4_stall_tx", tx_o, 1);
      chk("t4_stall_a", data_o, 32'h22);
      step();
      chk("t4_stall_b", data_o, 32'h22);
      step();
      chk("t4_stall_c", data_o, 32'h22);
      take("t4_p2", 32'h22);
      take("t4_p3", 32'h33);
      chk("t4_sending_end", sending_o, 0);
      chk("t4_credit", credit_o, 1);

      // Streaming two packets back to back, ack given whenever req_o is seen
      stim[0]  = 32'h0000_0505;
      stim[1]  = 32'd8;
      stim[10] = 32'h0000_0606;
      stim[11] = 32'd8;
      for (int i = 0; i < 8; i++) begin
         stim[2 + i]  = 32'h1000 + i;
         stim[12 + i] = 32'h2000 + i;
      end
      wi = 0;
      ri = 0;
      credit_in = 1'b1;
      for (int cyc = 0; cyc < 300 && ri < 20; cyc++) begin
         ack = req_o;
         if (tx_o) begin
            chk("t5_flit", data_o, stim[ri]);
            ri++;
         end
         if (credit_o && wi < 20) begin
            rx = 1'b1;
            din = stim[wi];
            wi++;
         end else begin
            rx = 1'b0;
         end
         step();
      end
      rx = 1'b0;
      ack = 1'b0;
      chk("t5_count", ri, 20);
      chk("t5_sending_end", sending_o, 0);

      // Reset asserted mid-payload
      send(32'h0000_0707);
      send(32'd4);
      for (int k = 1; k <= 4; k++) send(k);
      wait_req();
      grant();
      take("t6_hdr", 32'h0000_0707);
      take("t6_size", 32'd4);
      take("t6_p1", 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_req", req_o, 0);
      chk("t6_rst_sending", sending_o, 0);
      chk("t6_rst_tx", tx_o, 0);
      chk("t6_rst_credit", credit_o, 1);
`ifdef HERMES_BUFFER_OCC_EN
      chk("t6_rst_occ", occ, 0);
      chk("t6_rst_ovf", ovf, 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      send(32'h0000_0808);
      send(32'd1);
      send(32'h99);
      wait_req();
      grant();
      take("t6_hdr2", 32'h0000_0808);
      take("t6_size2", 32'd1);
      take("t6_p2", 32'h99);
      chk("t6_sending_end", sending_o, 0);
      chk("t6_tx_end", tx_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
